fifo_ctrl: RTL and testbench

- Pointer/flag controller that sits directly upstream of the FIFO storage register file.
- Converts push/pop requests into the storage's write enable, write address and read address.
- Tracks occupancy and produces full/empty/almost flags.
- Storage plus this controller form the team's standard synchronous FIFO; read data comes combinationally from storage at r_addr.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_ptr.sv | 34 +++
 rtl/fifo_ctrl.sv | 124 ++++++++++++
 tb/tb_fifo_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO pointer/flag controller:
// depth and count-width helpers plus the {wr,rd} operation encoding.
package fifo_pkg;

  // Number of storage entries addressed by an ADDR_WIDTH-bit pointer.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Bits needed to hold an occupancy of 0..DEPTH (equals ADDR_WIDTH+1).
  function automatic int fifo_cnt_w(input int addr_width);
    return $clog2((1 << addr_width) + 1);
  endfunction

  // Effective operation for one cycle, encoded as {do_wr, do_rd}.
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_RD    = 2'b01,
    OP_WR    = 2'b10,
    OP_WR_RD = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register with increment enable. Wraps modulo 2**W
// through natural overflow of the W-bit register.
module fifo_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Next pointer: advance by one when enabled, otherwise hold.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  // Pointer register, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for the synchronous FIFO storage register file.
// Turns push/pop requests into the storage write strobe and addresses and
// keeps registered occupancy, full and empty flags; almost flags are decoded
// from the registered count.
// Optional build macro FIFO_CTRL_ERR_EN adds sticky overflow/underflow outputs.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_CTRL_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int CW = fifo_cnt_w(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth(ADDR_WIDTH));
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          full_q;
  logic          full_d;
  logic          empty_q;
  logic          empty_d;
  logic          do_wr;
  logic          do_rd;
  fifo_op_e      op;

  // Effective operations from the flags held before the edge. A pop on an
  // empty FIFO is ignored; a push on a full FIFO only proceeds when a pop
  // frees the slot in the same cycle.
  always_comb begin
    do_rd   = rd & ~empty_q;
    do_wr   = wr & (~full_q | do_rd);
    op      = fifo_op_e'({do_wr, do_rd});
    count_d = count_q;
    case (op)
      OP_WR:    count_d = count_q + CW'(1);
      OP_RD:    count_d = count_q - CW'(1);
      OP_NOP:   count_d = count_q;
      OP_WR_RD: count_d = count_q;
      default:  count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  // Occupancy and flag registers; reset leaves the FIFO empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  fifo_ptr #(.W(ADDR_WIDTH)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (do_wr),
    .ptr_o   (w_addr)
  );

  fifo_ptr #(.W(ADDR_WIDTH)) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (do_rd),
    .ptr_o   (r_addr)
  );

  assign wr_en        = do_wr;
  assign full         = full_q;
  assign empty        = empty_q;
  assign count        = count_q;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

`ifdef FIFO_CTRL_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags: set by a dropped push or an ignored pop, cleared
  // only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr & full_q & ~rd) begin
        overflow_q <= 1'b1;
      end
      if (rd & empty_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (ADDR_WIDTH=2). A behavioural model
// predicts pointers, count and flags; a data scoreboard pushes each accepted
// word and pops it when the controller presents it at r_addr.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic       wr_en;
  logic [1:0] w_addr;
  logic [1:0] r_addr;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] count;
`ifdef FIFO_CTRL_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  logic [7:0] w_data = 8'h00;
  logic [7:0] mem [4];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int m_count = 0;
  int m_wp    = 0;
  int m_rp    = 0;
  int m_ovf   = 0;
  int m_udf   = 0;
  logic [7:0] sb_q [$];

  fifo_ctrl #(.ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr           (wr),
    .rd           (rd),
    .wr_en        (wr_en),
    .w_addr       (w_addr),
    .r_addr       (r_addr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef FIFO_CTRL_ERR_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  always #5 clk = ~clk;

  // Storage register file the controller drives.
  always @(posedge clk) begin
    if (wr_en) mem[w_addr] <= w_data;
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Compare every registered output against the model.
  task automatic chk_state();
    chk("count", int'(count), m_count);
    chk("w_addr", int'(w_addr), m_wp);
    chk("r_addr", int'(r_addr), m_rp);
    chk("full", int'(full), int'(m_count == 4));
    chk("empty", int'(empty), int'(m_count == 0));
    chk("almost_full", int'(almost_full), int'(m_count >= 3));
    chk("almost_empty", int'(almost_empty), int'(m_count <= 1));
`ifdef FIFO_CTRL_ERR_EN
    chk("overflow", int'(overflow), m_ovf);
    chk("underflow", int'(underflow), m_udf);
`endif
  endtask

  task automatic model_reset();
    m_count = 0;
    m_wp    = 0;
    m_rp    = 0;
    m_ovf   = 0;
    m_udf   = 0;
    sb_q.delete();
  endtask

  // One clock cycle with the given requests; called just after a rising edge.
  task automatic cycle(input logic w, input logic r);
    bit rd_ok;
    bit dw;
    logic [7:0] exp_d;
    wr     = w;
    rd     = r;
    w_data = 8'($urandom_range(0, 255));
    #1;
    rd_ok = r && (m_count != 0);
    dw    = w && ((m_count != 4) || rd_ok);
    chk("wr_en", int'(wr_en), int'(dw));
    if (rd_ok) begin
      if (sb_q.size() == 0) begin
        chk("sb_underrun", 1, 0);
      end else begin
        exp_d = sb_q.pop_front();
        chk("rdata", int'(mem[r_addr]), int'(exp_d));
      end
    end
    if (dw) sb_q.push_back(w_data);
    if (w && (m_count == 4) && !r) m_ovf = 1;
    if (r && (m_count == 0)) m_udf = 1;
    @(posedge clk);
    #1;
    m_wp    = (m_wp + int'(dw)) % 4;
    m_rp    = (m_rp + int'(rd_ok)) % 4;
    m_count = m_count + int'(dw) - int'(rd_ok);
    $display("txn wr=%0b rd=%0b wr_en=%0b count=%0d w_addr=%0d r_addr=%0d",
             w, r, wr_en, count, w_addr, r_addr);
    chk_state();
  endtask

  initial begin
    // Reset state
    model_reset();
    #12;
    chk_state();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Three pushes, then asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    wr = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_state();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full, then a dropped push
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);

    // Drain to empty, then an ignored pop
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);

    // Simultaneous push/pop while full
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);

    // Drain, then simultaneous push/pop while empty
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);

    // Two resident entries, ten push/pop pairs across the wrap
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1);

    // Final drain plus idle cycle
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    chk("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
